mod_updown_counter: RTL

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_next.sv | 59 +++++
 rtl/mod_updown_counter.sv | 92 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared encodings and parameter legality check for the
//                modulo up/down counter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Direction encodings driven on 'up'
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Mode encodings driven on 'oneshot'
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // A terminal count is legal when it is at least 1 and fits in WIDTH bits
    function automatic bit max_legal(input int width, input int max);
        longint lim;
        lim = (longint'(1) << width) - 1;
        return (max >= 1) && (longint'(max) <= lim);
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : counter_next
//  Description : Combinational next-state for one enabled counting step.
//                Produces the stepped count, the wrap event, the one-shot
//                done flag and the terminal indication for the current
//                direction. Load/hold selection lives in the register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             oneshot,
    input  logic             done,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next,
    output logic             done_next,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] c_max  = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic w_top;
    logic w_bot;

    // Step result assuming the enable is asserted on this edge
    always_comb begin
        w_top     = (q == c_max);
        w_bot     = (q == c_zero);
        at_term   = (up == DIR_UP) ? w_top : w_bot;
        q_next    = q;
        wrap_next = 1'b0;
        // done survives only while the one-shot mode remains selected
        done_next = done & (oneshot == MODE_ONESHOT);
        if ((oneshot == MODE_ONESHOT) && done) begin
            // Finished one-shot: count frozen until load/reset/mode change
            q_next    = q;
            done_next = 1'b1;
        end else if (at_term) begin
            if (oneshot == MODE_ONESHOT) begin
                q_next    = q;
                done_next = 1'b1;
            end else begin
                q_next    = (up == DIR_UP) ? c_zero : c_max;
                wrap_next = 1'b1;
            end
        end else begin
            q_next = (up == DIR_UP) ? (q + 1'b1) : (q - 1'b1);
        end
    end

endmodule : counter_next
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_updown_counter
//  Description : Modulo (0..MAX) up/down counter with synchronous load,
//                free-run/one-shot modes, registered wrap pulse, sticky done
//                flag and a combinational terminal-count output for
//                cascading stages through their enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_max = MAX[WIDTH-1:0];

    // Reject terminal counts that are zero or do not fit in WIDTH bits
    if (!max_legal(WIDTH, MAX)) begin : g_bad_max
        $error("mod_updown_counter: MAX must satisfy 1 <= MAX <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_done_next;
    logic             w_at_term;
    logic [WIDTH-1:0] w_load_clamped;

    counter_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .q         (r_q),
        .up        (up),
        .oneshot   (oneshot),
        .done      (r_done),
        .q_next    (w_q_next),
        .wrap_next (w_wrap_next),
        .done_next (w_done_next),
        .at_term   (w_at_term)
    );

    // Out-of-range load values saturate to the terminal count
    always_comb begin
        w_load_clamped = (load_val > c_max) ? c_max : load_val;
    end

    // Register stage: reset beats load beats enable; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_clamped;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (en) begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_done <= w_done_next;
        end else begin
            r_wrap <= 1'b0;
            r_done <= r_done & (oneshot == MODE_ONESHOT);
        end
    end

    // Terminal count is raw (mode-independent) so the next stage can count on it
    assign tc   = en & w_at_term;
    assign q    = r_q;
    assign wrap = r_wrap;
    assign done = r_done;

endmodule : mod_updown_counter
`default_nettype wire
